// File: rtl/dmem_responder.sv
// dmem_responder
//   Responder end of sram_if. Word-addressed single-port data array behind a
//   small posted write buffer (WBUF). Reads are combinational and see buffered
//   writes through byte-wise forwarding. Buffered writes are committed to the
//   array on cycles where no in-range read holds the array port.
//
// Ports
//   clk, rst_n      core clock (posedge), asynchronous active-low reset
//   sram_rd_en      read request this cycle
//   sram_rd_addr    read byte address ([1:0] ignored)
//   sram_rd_data    read word, combinational; 0 when idle or out of range
//   sram_wr_en      write request this cycle
//   sram_wr_addr    write byte address ([1:0] ignored)
//   sram_wr_data    write word, already lane-aligned by the master
//   sram_mask       byte enables, bit i -> data[8i+7:8i]
//   sram_stall      WBUF full; a write this cycle is not taken, master holds it
//   sram_err        registered pulse after an out-of-range access
module dmem_responder #(
    parameter int unsigned                  ADDR_WIDTH   = 32,
    parameter int unsigned                  DATA_WIDTH   = 32,
    parameter int unsigned                  NUM_OF_BYTES = DATA_WIDTH / 8,
    parameter logic [ADDR_WIDTH-1:0]        BASE_ADDR    = 32'h1c00_0000,
    parameter int unsigned                  DEPTH_WORDS  = 1024,
    parameter int unsigned                  WBUF_DEPTH   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sram_rd_en,
    input  logic [ADDR_WIDTH-1:0]   sram_rd_addr,
    output logic [DATA_WIDTH-1:0]   sram_rd_data,
    input  logic                    sram_wr_en,
    input  logic [ADDR_WIDTH-1:0]   sram_wr_addr,
    input  logic [DATA_WIDTH-1:0]   sram_wr_data,
    input  logic [NUM_OF_BYTES-1:0] sram_mask,
    output logic                    sram_stall,
    output logic                    sram_err
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned PTR_W = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(WBUF_DEPTH + 1);
    // Byte span of the array, one bit wider than the address so the upper
    // bound cannot overflow near the top of the address space.
    localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(DEPTH_WORDS) << 2;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return (a >= BASE_ADDR) && (({1'b0, a} - {1'b0, BASE_ADDR}) < SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_WIDTH-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(WBUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Data array (contents are not reset)
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH_WORDS];

    // Write buffer state
    logic [IDX_W-1:0]        buf_idx_q  [WBUF_DEPTH];
    logic [IDX_W-1:0]        buf_idx_d  [WBUF_DEPTH];
    logic [DATA_WIDTH-1:0]   buf_data_q [WBUF_DEPTH];
    logic [DATA_WIDTH-1:0]   buf_data_d [WBUF_DEPTH];
    logic [NUM_OF_BYTES-1:0] buf_mask_q [WBUF_DEPTH];
    logic [NUM_OF_BYTES-1:0] buf_mask_d [WBUF_DEPTH];
    logic [PTR_W-1:0]        head_q, head_d;
    logic [PTR_W-1:0]        tail_q, tail_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    err_q, err_d;

    logic                    rd_in, wr_in;
    logic [IDX_W-1:0]        rd_idx, wr_idx;
    logic [PTR_W-1:0]        youngest;
    logic                    drain, wr_accept, coalesce, push;
    logic [DATA_WIDTH-1:0]   rd_word;
    int unsigned             fwd_pos;

    assign rd_in      = in_range(sram_rd_addr);
    assign wr_in      = in_range(sram_wr_addr);
    assign rd_idx     = to_idx(sram_rd_addr);
    assign wr_idx     = to_idx(sram_wr_addr);

    assign sram_stall = (count_q == CNT_W'(WBUF_DEPTH));
    assign sram_err   = err_q;

    assign youngest   = (tail_q == '0) ? PTR_W'(WBUF_DEPTH - 1) : tail_q - 1'b1;

    // Reads own the array port; the head entry commits only when it is free.
    assign drain      = (count_q != '0) && !(sram_rd_en && rd_in);
    assign wr_accept  = sram_wr_en && !sram_stall && wr_in && (sram_mask != '0);
    // The youngest entry is also the head when count==1; merging into an entry
    // that is committing this cycle would lose the new bytes.
    assign coalesce   = wr_accept && (count_q != '0) && (buf_idx_q[youngest] == wr_idx)
                        && !(drain && (count_q == CNT_W'(1)));
    assign push       = wr_accept && !coalesce;

    // Read path: array word overlaid oldest->youngest with matching buffered bytes.
    always_comb begin
        rd_word = mem_q[rd_idx];
        fwd_pos = 0;
        for (int unsigned k = 0; k < WBUF_DEPTH; k++) begin
            fwd_pos = 32'(head_q) + k;
            if (fwd_pos >= WBUF_DEPTH) begin
                fwd_pos = fwd_pos - WBUF_DEPTH;
            end
            if ((k < 32'(count_q)) && (buf_idx_q[PTR_W'(fwd_pos)] == rd_idx)) begin
                for (int unsigned b = 0; b < NUM_OF_BYTES; b++) begin
                    if (buf_mask_q[PTR_W'(fwd_pos)][b]) begin
                        rd_word[8*b +: 8] = buf_data_q[PTR_W'(fwd_pos)][8*b +: 8];
                    end
                end
            end
        end
        sram_rd_data = (sram_rd_en && rd_in) ? rd_word : '0;
    end

    // Write buffer next state
    always_comb begin
        buf_idx_d  = buf_idx_q;
        buf_data_d = buf_data_q;
        buf_mask_d = buf_mask_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        err_d      = (sram_rd_en && !rd_in) || (sram_wr_en && !wr_in);

        if (drain) begin
            head_d = ptr_inc(head_q);
        end

        if (coalesce) begin
            for (int unsigned b = 0; b < NUM_OF_BYTES; b++) begin
                if (sram_mask[b]) begin
                    buf_data_d[youngest][8*b +: 8] = sram_wr_data[8*b +: 8];
                end
            end
            buf_mask_d[youngest] = buf_mask_q[youngest] | sram_mask;
        end else if (push) begin
            buf_idx_d[tail_q]  = wr_idx;
            buf_data_d[tail_q] = sram_wr_data;
            buf_mask_d[tail_q] = sram_mask;
            tail_d             = ptr_inc(tail_q);
        end

        if (push && !drain) begin
            count_d = count_q + 1'b1;
        end else if (!push && drain) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_idx_q  <= '{default: '0};
            buf_data_q <= '{default: '0};
            buf_mask_q <= '{default: '0};
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            buf_idx_q  <= buf_idx_d;
            buf_data_q <= buf_data_d;
            buf_mask_q <= buf_mask_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            err_q      <= err_d;
        end
    end

    // Array commit of the head entry, byte-masked
    always_ff @(posedge clk) begin
        if (drain) begin
            for (int unsigned b = 0; b < NUM_OF_BYTES; b++) begin
                if (buf_mask_q[head_q][b]) begin
                    mem_q[buf_idx_q[head_q]][8*b +: 8] <= buf_data_q[head_q][8*b +: 8];
                end
            end
        end
    end

endmodule
